// File: rtl/display_scanner_pkg.sv
// display_pkg: shared game-state enum and 7-seg character codes for the display_scanner slice.
package display_pkg;
  typedef enum logic [2:0] {SECRET_J1, SECRET_J2, GUESS_J1, GUESS_J2, RESULT, FIM} state_t;
  localparam int CODE_W_DEF = 6;
  localparam logic [CODE_W_DEF-1:0] BLANK_CODE = 6'b100000;
  function automatic logic [CODE_W_DEF-1:0] glyph(input logic [3:0] g);
    return {1'b0, g, 1'b0};
  endfunction
  localparam logic [CODE_W_DEF-1:0] C_J = 6'b001011;
  localparam logic [CODE_W_DEF-1:0] C_S = glyph(4'd13);
  localparam logic [CODE_W_DEF-1:0] C_E = glyph(4'd7);
  localparam logic [CODE_W_DEF-1:0] C_T = glyph(4'd15);
  localparam logic [CODE_W_DEF-1:0] C_U = glyph(4'd14);
  localparam logic [CODE_W_DEF-1:0] C_P = glyph(4'd12);
  localparam logic [CODE_W_DEF-1:0] C_G = glyph(4'd6);
  localparam logic [CODE_W_DEF-1:0] C_B = glyph(4'd8);
  localparam logic [CODE_W_DEF-1:0] C_L = glyph(4'd9);
  localparam logic [CODE_W_DEF-1:0] C_Y = glyph(4'd4);
  localparam logic [CODE_W_DEF-1:0] C_O = glyph(4'd0);
  localparam logic [CODE_W_DEF-1:0] C_V = glyph(4'd10);
  localparam logic [CODE_W_DEF-1:0] C_A = glyph(4'd11);
endpackage

// File: rtl/display_scanner_if.sv
// display_scanner_if: frame-load handshake and scan outputs between display logic and the scanner.
interface display_scanner_if #(parameter int N_DIGITS = 8, parameter int CODE_W = 6);
  localparam int IW = $clog2(N_DIGITS);
  logic load;
  logic [N_DIGITS*CODE_W-1:0] codes_in;
  logic [N_DIGITS-1:0] blink_mask;
  logic load_ack;
  logic frame_start;
  logic [N_DIGITS-1:0] an_n;
  logic [CODE_W-1:0] code_out;
  logic [IW-1:0] digit_idx;
  modport master(output load, codes_in, blink_mask, input load_ack, frame_start, an_n, code_out, digit_idx);
  modport slave(input load, codes_in, blink_mask, output load_ack, frame_start, an_n, code_out, digit_idx);
endinterface

// File: rtl/display_scanner_scan_timer.sv
// scan_timer: refresh prescaler and digit index counter with slot/frame strobes.
module scan_timer #(
  parameter int N_DIGITS = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic slot_tick,
  output logic frame_wrap
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  logic [PW-1:0] cnt;
  assign slot_tick = cnt == PW'(REFRESH_DIV - 1);
  assign frame_wrap = slot_tick && digit_idx == IW'(N_DIGITS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      digit_idx <= '0;
    end else begin
      cnt <= slot_tick ? '0 : cnt + 1'b1;
      if (slot_tick) digit_idx <= frame_wrap ? '0 : digit_idx + 1'b1;
    end
  end
endmodule

// File: rtl/display_scanner.sv
// display_scanner: tear-free double-buffered 7-seg scanner; define DISPLAY_BLINK_EN for per-digit blinking.
module display_scanner
  import display_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int CODE_W = CODE_W_DEF,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input logic clk,
  input logic rst_n,
  display_scanner_if.slave bus
);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CODE_W-1:0] BLANK = {1'b1, {(CODE_W-1){1'b0}}};
  logic [N_DIGITS-1:0][CODE_W-1:0] active, pending;
  logic pending_valid, slot_tick, frame_wrap, wrap, dark;
  logic [IW-1:0] idx;
  logic [CODE_W-1:0] cur;
  scan_timer #(.N_DIGITS(N_DIGITS), .REFRESH_DIV(REFRESH_DIV)) u_timer (
    .clk(clk), .rst_n(rst_n), .digit_idx(idx), .slot_tick(slot_tick), .frame_wrap(frame_wrap)
  );
  assign wrap = slot_tick & frame_wrap;
  assign cur = active[idx];
  assign bus.digit_idx = idx;
`ifdef DISPLAY_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] fcnt;
  logic phase_on, last;
  assign last = fcnt == FW'(BLINK_FRAMES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      phase_on <= 1'b1;
    end else if (wrap) begin
      fcnt <= last ? '0 : fcnt + 1'b1;
      if (last) phase_on <= ~phase_on;
    end
  end
  assign dark = cur[CODE_W-1] | (bus.blink_mask[idx] & ~phase_on);
`else
  wire unused_mask = ^bus.blink_mask;
  assign dark = cur[CODE_W-1];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= {N_DIGITS{BLANK}};
      pending <= {N_DIGITS{BLANK}};
      pending_valid <= 1'b0;
      bus.load_ack <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.an_n <= '1;
      bus.code_out <= BLANK;
    end else begin
      bus.load_ack <= wrap && (bus.load || pending_valid);
      bus.frame_start <= wrap;
      // a load landing on the wrap cycle skips the pending stage entirely
      if (wrap && bus.load) begin
        active <= bus.codes_in;
        pending_valid <= 1'b0;
      end else if (wrap && pending_valid) begin
        active <= pending;
        pending_valid <= 1'b0;
      end else if (bus.load) begin
        pending <= bus.codes_in;
        pending_valid <= 1'b1;
      end
      bus.code_out <= cur;
      bus.an_n <= dark ? '1 : ~(N_DIGITS'(1) << idx);
    end
  end
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: scoreboard bench; loads queue expected frames, a negedge monitor checks every scan cycle.
module tb_display_scanner;
  localparam int N = 8, W = 6, DIV = 4, BF = 2, FR = N * DIV;
`ifdef DISPLAY_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  localparam logic [N*W-1:0] BLANK_F = {N{6'b100000}};
  localparam logic [N*W-1:0] F1 = {6'b011000, 6'b011100, 6'b011110, 6'b001110, 6'b011010, 6'b100000, 6'b000010, 6'b001011};
  localparam logic [N*W-1:0] FA = {6'b010110, 6'b010110, 6'b010110, 6'b010110, 6'b010110, 6'b010110, 6'b010110, 6'b010110};
  localparam logic [N*W-1:0] FB = {6'b000001, 6'b000011, 6'b000101, 6'b000111, 6'b001001, 6'b001101, 6'b010001, 6'b011111};
  localparam logic [N*W-1:0] FC = {6'b000100, 6'b001000, 6'b001100, 6'b010000, 6'b010100, 6'b100000, 6'b011000, 6'b000110};
  localparam logic [N*W-1:0] FD = {6'b010010, 6'b010010, 6'b010010, 6'b010010, 6'b010010, 6'b010010, 6'b010010, 6'b000000};
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  display_scanner_if #(.N_DIGITS(N), .CODE_W(W)) bus();
  display_scanner #(.N_DIGITS(N), .CODE_W(W), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int passed = 0, total = 0, pe = 0, wraps = 0, e, ip;
  logic [N*W-1:0] q[$];
  logic [N*W-1:0] model = BLANK_F;
  logic [N-1:0] mask_prev = '0, ea;
  logic [W-1:0] c;
  logic dk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask
  always @(posedge clk) pe = rst_n ? pe + 1 : 0;
  // scoreboard monitor: outputs after edge e reflect the frame, mask and phase in force before that edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset an_n", 32'(bus.an_n), 32'hFF);
      check("reset code_out", 32'(bus.code_out), 32'h20);
      check("reset digit_idx", 32'(bus.digit_idx), 32'h0);
      check("reset load_ack", 32'(bus.load_ack), 32'h0);
      check("reset frame_start", 32'(bus.frame_start), 32'h0);
      wraps = 0;
      mask_prev = bus.blink_mask;
    end else if (pe > 0) begin
      e = pe;
      ip = ((e - 1) / DIV) % N;
      c = model[ip*W +: W];
      dk = c[W-1] | (BLINK && mask_prev[ip] && ((wraps / BF) % 2 != 0));
      ea = dk ? '1 : ~(8'(1) << ip);
      check("code_out", 32'(bus.code_out), 32'(c));
      check("an_n", 32'(bus.an_n), 32'(ea));
      check("digit_idx", 32'(bus.digit_idx), 32'((e / DIV) % N));
      check("frame_start", 32'(bus.frame_start), 32'(e % FR == 0));
      check("load_ack", 32'(bus.load_ack), 32'(e % FR == 0 && q.size() != 0));
      if (e % FR == 0) begin
        if (q.size() != 0) model = q.pop_front();
        wraps++;
      end
      mask_prev = bus.blink_mask;
    end
  end
  task automatic wait_pe(input int n);
    int b = 0;
    while (pe < n && b < 5000) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (pe != n) begin
      total++;
      $display("FAIL wait_pe: got %0d expected %0d", pe, n);
    end
  endtask
  task automatic load_at(input int n, input logic [N*W-1:0] f, input bit replace);
    wait_pe(n - 1);
    bus.load = 1'b1;
    bus.codes_in = f;
    if (replace && q.size() != 0) void'(q.pop_back());
    q.push_back(f);
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask
  initial begin
    bus.load = 1'b0;
    bus.codes_in = '0;
    bus.blink_mask = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    load_at(40, F1, 1'b0);
    load_at(70, FA, 1'b0);
    load_at(80, FB, 1'b1);
    load_at(128, FC, 1'b0);
    load_at(150, FD, 1'b0);
    bus.blink_mask = 8'h01;
    load_at(340, FA, 1'b0);
    wait_pe(343);
    #2 rst_n = 1'b0;
    #1;
    check("async an_n", 32'(bus.an_n), 32'hFF);
    check("async code_out", 32'(bus.code_out), 32'h20);
    check("async load_ack", 32'(bus.load_ack), 32'h0);
    q.delete();
    model = BLANK_F;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_pe(70);
    check("queue drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
